tag_tx_ctrl_hop: RTL and testbench

Anchor-side transmit controller for the frequency-hopping tag link. It is the counterpart of the tag receive controller. On a start request it drives the GPIO sync trigger to the receiving node. It then streams a square-wave localisation sync burst, followed by NUM_HOPS hops, each made of a zero-filled guard interval and NSIG tone samples taken from the upstream NCO. It sits between the NCO/IQ source and the DAC-side IQ path, and counts accepted samples so that its hop boundaries line up with the receiver's.

---
 rtl/tag_hop_pkg.sv | 17 +
 rtl/tag_tx_sync_gen.sv | 20 ++
 rtl/tag_tx_ctrl_hop.sv | 186 ++++++++++++++++++
 tb/tb_tag_tx_ctrl_hop.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_hop_pkg.sv
// Shared definitions for the frequency-hopping tag link (anchor TX and tag RX controllers).
package tag_hop_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StTrig     = 3'd1,
        StLocSync  = 3'd2,
        StHopGuard = 3'd3,
        StHopTx    = 3'd4
    } tx_state_e;

    localparam logic [11:0] SYNC_OUT_MASK = 12'h002;
    localparam logic [11:0] TX_OUT_MASK   = 12'h001;

    localparam int unsigned SYNC_AMP_DEFAULT = 28672;

endpackage

// File: rtl/tag_tx_sync_gen.sv
// Square-wave localisation sync generator: +amp in the first half of the countdown, -amp after.
module tag_tx_sync_gen #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 24,
    parameter int unsigned SYNC_AMP   = 28672
) (
    input  logic [CNT_WIDTH-1:0]  cnt,
    input  logic [CNT_WIDTH-1:0]  half,
    output logic [DATA_WIDTH-1:0] itx,
    output logic [DATA_WIDTH-1:0] qtx
);

    localparam logic [DATA_WIDTH-1:0] AmpPos = DATA_WIDTH'(SYNC_AMP);
    localparam logic [DATA_WIDTH-1:0] AmpNeg = -AmpPos;

    // cnt counts down, so the high half of the range is the first half in time.
    assign itx = (cnt >= half) ? AmpPos : AmpNeg;
    assign qtx = '0;

endmodule

// File: rtl/tag_tx_ctrl_hop.sv
// Anchor-side frequency-hopping transmit controller: GPIO trigger, sync burst, guard/tone hops.
// Define TAG_TX_HOP_LOOP_EN to repeat frames until abort instead of returning to idle.
module tag_tx_ctrl_hop
    import tag_hop_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned GPIO_REG_WIDTH = 12,
    parameter int unsigned NSIG_WIDTH     = 24,
    parameter int unsigned NSYNC_WIDTH    = 24,
    parameter int unsigned HOP_WIDTH      = 7,
    parameter int unsigned NUM_HOPS       = 64,
    parameter int unsigned NSIG           = 294912,
    parameter int unsigned NSYNC_LOC      = 16384,
    parameter int unsigned NSYNC_HOP      = 16384,
    parameter int unsigned TRIG_LEN       = 16,
    parameter int unsigned SYNC_AMP       = SYNC_AMP_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DATA_WIDTH-1:0]     itx_in,
    input  logic [DATA_WIDTH-1:0]     qtx_in,
    input  logic                      tx_ready,
    output logic [DATA_WIDTH-1:0]     itx_out,
    output logic [DATA_WIDTH-1:0]     qtx_out,
    output logic                      tx_valid,
    output logic [GPIO_REG_WIDTH-1:0] gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] gpio_ddr,
    output logic [HOP_WIDTH-1:0]      hop_n,
    output logic                      hop_stb,
    output logic [2:0]                tx_state,
    output logic                      busy,
    output logic                      done
);

    localparam logic [NSYNC_WIDTH-1:0] TrigLoad  = NSYNC_WIDTH'(TRIG_LEN - 1);
    localparam logic [NSYNC_WIDTH-1:0] LocLoad   = NSYNC_WIDTH'(NSYNC_LOC - 1);
    localparam logic [NSYNC_WIDTH-1:0] LocHalf   = NSYNC_WIDTH'(NSYNC_LOC / 2);
    localparam logic [NSYNC_WIDTH-1:0] GuardLoad = NSYNC_WIDTH'(NSYNC_HOP - 1);
    localparam logic [NSIG_WIDTH-1:0]  SigLoad   = NSIG_WIDTH'(NSIG - 1);

    tx_state_e              state_q, state_d;
    logic [NSYNC_WIDTH-1:0] cnt_q, cnt_d;
    logic [NSIG_WIDTH-1:0]  nsig_q, nsig_d;
    logic [HOP_WIDTH-1:0]   hop_q, hop_d;
    logic                   hop_stb_q, hop_stb_d;
    logic                   done_q, done_d;
    logic [DATA_WIDTH-1:0]  sync_i, sync_q;
    logic                   accept;

    tag_tx_sync_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (NSYNC_WIDTH),
        .SYNC_AMP   (SYNC_AMP)
    ) u_sync_gen (
        .cnt  (cnt_q),
        .half (LocHalf),
        .itx  (sync_i),
        .qtx  (sync_q)
    );

    always_comb begin
        tx_valid = 1'b0;
        itx_out  = '0;
        qtx_out  = '0;
        unique case (state_q)
            StLocSync: begin
                tx_valid = 1'b1;
                itx_out  = sync_i;
                qtx_out  = sync_q;
            end
            StHopGuard: tx_valid = 1'b1;
            StHopTx: begin
                tx_valid = 1'b1;
                itx_out  = itx_in;
                qtx_out  = qtx_in;
            end
            default: ;
        endcase
    end

    assign accept = tx_valid & tx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nsig_d    = nsig_q;
        hop_d     = hop_q;
        hop_stb_d = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            state_d = StIdle;
            hop_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StTrig;
                        cnt_d   = TrigLoad;
                        hop_d   = '0;
                    end
                end
                StTrig: begin
                    if (cnt_q == '0) begin
                        state_d = StLocSync;
                        cnt_d   = LocLoad;
                    end else begin
                        cnt_d = cnt_q - NSYNC_WIDTH'(1);
                    end
                end
                StLocSync: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            state_d   = StHopGuard;
                            cnt_d     = GuardLoad;
                            hop_stb_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - NSYNC_WIDTH'(1);
                        end
                    end
                end
                StHopGuard: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            state_d = StHopTx;
                            nsig_d  = SigLoad;
                        end else begin
                            cnt_d = cnt_q - NSYNC_WIDTH'(1);
                        end
                    end
                end
                StHopTx: begin
                    if (accept) begin
                        if (nsig_q != '0) begin
                            nsig_d = nsig_q - NSIG_WIDTH'(1);
                        end else if (32'(hop_q) < NUM_HOPS - 1) begin
                            state_d   = StHopGuard;
                            cnt_d     = GuardLoad;
                            hop_d     = hop_q + HOP_WIDTH'(1);
                            hop_stb_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            hop_d  = '0;
`ifdef TAG_TX_HOP_LOOP_EN
                            state_d = StTrig;
                            cnt_d   = TrigLoad;
`else
                            state_d = StIdle;
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            nsig_q    <= '0;
            hop_q     <= '0;
            hop_stb_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nsig_q    <= nsig_d;
            hop_q     <= hop_d;
            hop_stb_q <= hop_stb_d;
            done_q    <= done_d;
        end
    end

    assign gpio_out = ((state_q == StTrig)  ? GPIO_REG_WIDTH'(SYNC_OUT_MASK) : '0)
                    | ((state_q == StHopTx) ? GPIO_REG_WIDTH'(TX_OUT_MASK)   : '0);
    assign gpio_ddr = GPIO_REG_WIDTH'(SYNC_OUT_MASK | TX_OUT_MASK);
    assign hop_n    = hop_q;
    assign hop_stb  = hop_stb_q;
    assign tx_state = state_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

endmodule

// File: tb/tb_tag_tx_ctrl_hop.sv
// Directed bench for tag_tx_ctrl_hop with a small frame (3 hops, 8 tone, 8 sync, 4 guard, 4 trig).
module tb_tag_tx_ctrl_hop;

    localparam int FRAME = 48;  // 4 trig + 8 sync + 3*(4+8)
    localparam logic [15:0] APOS = 16'h7000;
    localparam logic [15:0] ANEG = 16'h9000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] itx_in = '0;
    logic [15:0] qtx_in = '0;
    logic        tx_ready = 1'b0;
    logic [15:0] itx_out, qtx_out;
    logic        tx_valid;
    logic [11:0] gpio_out, gpio_ddr;
    logic [6:0]  hop_n;
    logic        hop_stb;
    logic [2:0]  tx_state;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    tag_tx_ctrl_hop #(
        .NUM_HOPS  (3),
        .NSIG      (8),
        .NSYNC_LOC (8),
        .NSYNC_HOP (4),
        .TRIG_LEN  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .itx_in   (itx_in),
        .qtx_in   (qtx_in),
        .tx_ready (tx_ready),
        .itx_out  (itx_out),
        .qtx_out  (qtx_out),
        .tx_valid (tx_valid),
        .gpio_out (gpio_out),
        .gpio_ddr (gpio_ddr),
        .hop_n    (hop_n),
        .hop_stb  (hop_stb),
        .tx_state (tx_state),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [57:0] actual_vec();
        return {tx_state, tx_valid, itx_out, qtx_out, gpio_out, hop_n, hop_stb, done, busy};
    endfunction

    // Expected outputs at frame position pos (trig cycle index, then accepted-sample index).
    function automatic logic [57:0] exp_vec(int pos, bit first, logic [15:0] ii, logic [15:0] qi);
        logic [2:0]  st = 3'd0;
        logic        v = 1'b0, stb = 1'b0, d = 1'b0;
        logic [15:0] it = '0, qt = '0;
        logic [11:0] g = '0;
        logic [6:0]  h = '0;
        int p = pos;
        if (p >= FRAME) begin
            d = first && (p == FRAME);
`ifdef TAG_TX_HOP_LOOP_EN
            p = p - FRAME;
`else
            p = -1;
`endif
        end
        if (p < 0) begin
            st = 3'd0;
        end else if (p < 4) begin
            st = 3'd1;
            g  = 12'h002;
        end else if (p < 12) begin
            st = 3'd2;
            v  = 1'b1;
            it = (p - 4 < 4) ? APOS : ANEG;
        end else begin
            h = 7'((p - 12) / 12);
            v = 1'b1;
            if ((p - 12) % 12 < 4) begin
                st  = 3'd3;
                stb = first && ((p - 12) % 12 == 0);
            end else begin
                st = 3'd4;
                g  = 12'h001;
                it = ii;
                qt = qi;
            end
        end
        return {st, v, it, qt, g, h, stb, d, st != 3'd0};
    endfunction

    // Starts a frame and walks it to stop_pos, checking every cycle.
    task automatic run_frame(input int stop_pos, input bit toggle, input int start_at,
                             input string name, output int cycles, output int accepted);
        int pos = 0;
        int prev = -1;
        int cyc = 0;
        logic [57:0] e;
        accepted = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            itx_in   = 16'(cyc * 37 + 5);
            qtx_in   = 16'(cyc * 91 + 3);
            tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            start    = (pos == start_at);
            #1;
            e = exp_vec(pos, pos != prev, itx_in, qtx_in);
            checks++;
            if (actual_vec() !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d pos=%0d got=%h want=%h", name, cyc, pos, actual_vec(), e);
            end
            if (pos == stop_pos) break;
            if (cyc > 400) begin
                errors++;
                $display("FAIL %s timeout pos=%0d want_pos=%0d", name, pos, stop_pos);
                break;
            end
            prev = pos;
            if ((pos % FRAME) < 4) begin
                pos++;
            end else if (tx_ready) begin
                pos++;
                accepted++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        cycles = cyc;
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (actual_vec() !== exp_vec(-1, 1'b0, '0, '0)) begin
                errors++;
                $display("FAIL %s idle i=%0d got=%h want=%h", name, i, actual_vec(),
                         exp_vec(-1, 1'b0, '0, '0));
            end
        end
    endtask

    task automatic do_abort(input string name);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle(name, 3);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (actual_vec() !== exp_vec(-1, 1'b0, '0, '0)) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", actual_vec(), exp_vec(-1, 1'b0, '0, '0));
        end
        checks++;
        if (gpio_ddr !== 12'h003) begin
            errors++;
            $display("FAIL gpio_ddr got=%h want=003", gpio_ddr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        int cyc, acc;
        run_frame(FRAME, 1'b0, -1, "frame", cyc, acc);
        checks++;
        if (cyc != FRAME || acc != 44) begin
            errors++;
            $display("FAIL frame_len cycles=%0d acc=%0d want=48/44", cyc, acc);
        end
        do_abort("frame_end");
    endtask

    task automatic test_backpressure();
        int cyc, acc;
        run_frame(FRAME, 1'b1, -1, "bp", cyc, acc);
        checks++;
        if (cyc != 91 || acc != 44) begin
            errors++;
            $display("FAIL bp_len cycles=%0d acc=%0d want=91/44", cyc, acc);
        end
        do_abort("bp_end");
    endtask

    task automatic test_abort();
        int cyc, acc;
        run_frame(30, 1'b0, -1, "abort_pre", cyc, acc);
        do_abort("abort_hop1");
    endtask

    task automatic test_mid_start();
        int cyc, acc;
        run_frame(FRAME, 1'b0, 20, "mid_start", cyc, acc);
        checks++;
        if (cyc != FRAME) begin
            errors++;
            $display("FAIL mid_start_len cycles=%0d want=48", cyc);
        end
        do_abort("mid_start_end");
    endtask

    task automatic test_async_reset();
        int cyc, acc;
        run_frame(6, 1'b0, -1, "rst_pre", cyc, acc);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (actual_vec() !== exp_vec(-1, 1'b0, '0, '0)) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", actual_vec(), exp_vec(-1, 1'b0, '0, '0));
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_frame(FRAME, 1'b0, -1, "rst_post", cyc, acc);
        do_abort("rst_post_end");
    endtask

`ifdef TAG_TX_HOP_LOOP_EN
    task automatic test_loop();
        int cyc, acc;
        run_frame(2 * FRAME - 1, 1'b0, -1, "loop", cyc, acc);
        do_abort("loop_end");
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_abort();
        test_mid_start();
        test_async_reset();
`ifdef TAG_TX_HOP_LOOP_EN
        test_loop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
